// File: rtl/ups_dac_spi.sv
// ups_dac_spi
// -----------
// SPI transmitter for the UPS 16-bit output DAC. Accepts the controller's
// dac/dac_dv word stream and serialises each word MSB-first in SPI mode 0
// (SCLK idles low, DAC samples MOSI on the rising SCLK edge). A one-deep,
// latest-wins pending buffer absorbs words that arrive while a frame is in
// flight. Every output is a flop, so nothing combinational reaches the pins.
//
// Frame sequence: IDLE -> SETUP -> SHIFT -> HOLD -> [LDAC] -> GAP -> IDLE.
// Each phase lasts CLK_DIV cycles; each SHIFT bit lasts 2*CLK_DIV cycles.
//
// Build option:
//   UPS_DAC_LDAC_EN  when defined, an LDAC phase follows CS rising and
//                    pulses spi_ldac_n low for CLK_DIV cycles. When
//                    undefined, spi_ldac_n is tied high and the DAC updates
//                    on the rising edge of spi_cs_n.
//
// Parameters:
//   CLK_DIV     SCLK half-period in clk cycles, 1..255
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   dac         word to transmit, sampled when dac_dv=1
//   dac_dv      single-cycle valid strobe for dac
//   busy        high whenever the frame machine is not idle
//   done        one-cycle pulse in the first idle cycle after a frame
//   overrun     one-cycle pulse when an unsent pending word is overwritten
//   spi_cs_n    DAC chip select, active low
//   spi_sclk    serial clock
//   spi_mosi    serial data, MSB first
//   spi_ldac_n  DAC load strobe, active low

module ups_dac_spi #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] dac,
    input  logic        dac_dv,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_ldac_n
);

    // Phase counter reload value: each phase counts CLK_DIV-1 down to 0.
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
`ifdef UPS_DAC_LDAC_EN
        LDAC,
`endif
        GAP
    } state_t;

    state_t      state;
    logic [7:0]  div_cnt;     // cycles left in the current phase
    logic [3:0]  bit_cnt;     // bit currently on MOSI, 15 -> 0
    logic [14:0] shreg;       // bits still to send after the one on MOSI
    logic [15:0] pend_word;
    logic        pend_vld;

    logic        phase_end;
    logic        load_en;
    logic [15:0] load_word;

    assign phase_end = (div_cnt == 8'd0);

    // A waiting pending word always takes priority over a fresh dac word,
    // so the older word is never skipped.
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        load_en   = 1'b0;
        load_word = dac;
        if (state == IDLE) begin
            if (pend_vld) begin
                load_en   = 1'b1;
                load_word = pend_word;
            end else if (dac_dv) begin
                load_en   = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= 8'd0;
            bit_cnt    <= 4'd0;
            shreg      <= 15'd0;
            pend_word  <= 16'd0;
            pend_vld   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
`ifdef UPS_DAC_LDAC_EN
            spi_ldac_n <= 1'b1;
`endif
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;

            // Pending buffer. In IDLE a valid pending word is consumed this
            // cycle; a simultaneous dac_dv refills it without an overrun.
            // Outside IDLE every dac_dv lands here, latest wins.
            if (state == IDLE) begin
                pend_vld <= pend_vld && dac_dv;
                if (pend_vld && dac_dv) begin
                    pend_word <= dac;
                end
            end else if (dac_dv) begin
                pend_word <= dac;
                pend_vld  <= 1'b1;
                overrun   <= pend_vld;
            end

            case (state)
                IDLE: begin
                    if (load_en) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        spi_cs_n <= 1'b0;
                        spi_sclk <= 1'b0;
                        spi_mosi <= load_word[15];
                        shreg    <= load_word[14:0];
                        div_cnt  <= DIV_LAST;
                    end
                end

                SETUP: begin
                    if (phase_end) begin
                        state   <= SHIFT;
                        bit_cnt <= 4'd15;
                        div_cnt <= DIV_LAST;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                // Each bit: low half then high half. MOSI only changes with
                // the falling edge that starts the next bit's low half.
                SHIFT: begin
                    if (!phase_end) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_LAST;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else if (bit_cnt == 4'd0) begin
                            state    <= HOLD;
                            spi_sclk <= 1'b0;
                            spi_mosi <= 1'b0;
                        end else begin
                            spi_sclk <= 1'b0;
                            bit_cnt  <= bit_cnt - 4'd1;
                            spi_mosi <= shreg[14];
                            shreg    <= {shreg[13:0], 1'b0};
                        end
                    end
                end

                HOLD: begin
                    if (phase_end) begin
                        div_cnt  <= DIV_LAST;
                        spi_cs_n <= 1'b1;
`ifdef UPS_DAC_LDAC_EN
                        state      <= LDAC;
                        spi_ldac_n <= 1'b0;
`else
                        state      <= GAP;
`endif
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

`ifdef UPS_DAC_LDAC_EN
                LDAC: begin
                    if (phase_end) begin
                        state      <= GAP;
                        div_cnt    <= DIV_LAST;
                        spi_ldac_n <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
`endif

                // Minimum CS-high time before the next frame may start.
                GAP: begin
                    if (phase_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifndef UPS_DAC_LDAC_EN
    // Without the LDAC phase the DAC updates on CS rising; keep LDAC inactive.
    assign spi_ldac_n = 1'b1;
`endif

endmodule

// File: tb/tb_ups_dac_spi.sv
// Testbench for ups_dac_spi. Two instances: CLK_DIV=4 and CLK_DIV=1, observed
// one at a time through a shared SPI-slave monitor. Expected frames come from
// an event-level model of the word stream (frame length, one pending slot,
// latest wins) rather than from cycle-by-cycle state.

module tb_ups_dac_spi;

    localparam int D0 = 4;
    localparam int D1 = 1;
`ifdef UPS_DAC_LDAC_EN
    localparam int LDAC_PH = 1;
`else
    localparam int LDAC_PH = 0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] dac0  = 16'd0;
    logic [15:0] dac1  = 16'd0;
    logic        dv0   = 1'b0;
    logic        dv1   = 1'b0;
    logic busy0, done0, ovr0, cs0, sclk0, mosi0, ldac0;
    logic busy1, done1, ovr1, cs1, sclk1, mosi1, ldac1;

    ups_dac_spi #(.CLK_DIV(D0)) dut0 (
        .clk(clk), .rst_n(rst_n), .dac(dac0), .dac_dv(dv0),
        .busy(busy0), .done(done0), .overrun(ovr0),
        .spi_cs_n(cs0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_ldac_n(ldac0)
    );

    ups_dac_spi #(.CLK_DIV(D1)) dut1 (
        .clk(clk), .rst_n(rst_n), .dac(dac1), .dac_dv(dv1),
        .busy(busy1), .done(done1), .overrun(ovr1),
        .spi_cs_n(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_ldac_n(ldac1)
    );

    logic sel = 1'b0;
    logic m_busy, m_done, m_ovr, m_cs, m_sclk, m_mosi, m_ldac;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_ovr  = sel ? ovr1  : ovr0;
    assign m_cs   = sel ? cs1   : cs0;
    assign m_sclk = sel ? sclk1 : sclk0;
    assign m_mosi = sel ? mosi1 : mosi0;
    assign m_ldac = sel ? ldac1 : ldac0;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Monitor logs
    int          cs_fall_q[$];
    int          len_q[$];
    int          rise_q[$];
    int          bits_q[$];
    int          done_q[$];
    int          ovr_q[$];
    int          ldac_q[$];
    int          ldac_len_q[$];
    logic [15:0] rx_q[$];
    int          ldac_bad = 0;
    int          mon_bits = 0;

    // Stimulus log and model output
    int          ev_cyc[$];
    logic [15:0] ev_word[$];
    int          exp_t[$];
    logic [15:0] exp_w[$];
    int          exp_ovr[$];

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SPI slave monitor, sampled on the falling clk edge.
    initial begin : monitor
        bit          prev_cs    = 1'b1;
        bit          prev_sclk  = 1'b0;
        bit          prev_ldac  = 1'b1;
        int          fall       = 0;
        int          first_rise = -1;
        int          lfall      = 0;
        logic [15:0] word       = 16'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_cs   = 1'b1;
                prev_sclk = 1'b0;
                prev_ldac = 1'b1;
                mon_bits  = 0;
            end else begin
                if (prev_cs && !m_cs) begin
                    fall       = cyc;
                    first_rise = -1;
                    word       = 16'd0;
                    mon_bits   = 0;
                    cs_fall_q.push_back(cyc);
                end
                if (!m_cs && m_sclk && !prev_sclk) begin
                    word = {word[14:0], m_mosi};
                    mon_bits++;
                    if (first_rise < 0) first_rise = cyc;
                end
                if (!prev_cs && m_cs) begin
                    rx_q.push_back(word);
                    bits_q.push_back(mon_bits);
                    len_q.push_back(cyc - fall);
                    rise_q.push_back(first_rise - fall);
                end
                if (m_done) done_q.push_back(cyc);
                if (m_ovr) ovr_q.push_back(cyc);
                if (prev_ldac && !m_ldac) lfall = cyc;
                if (!prev_ldac && m_ldac) begin
                    ldac_q.push_back(lfall);
                    ldac_len_q.push_back(cyc - lfall);
                end
                if (!m_ldac && !m_cs) ldac_bad++;
                prev_cs   = m_cs;
                prev_sclk = m_sclk;
                prev_ldac = m_ldac;
            end
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic clear_logs();
        cs_fall_q.delete(); len_q.delete(); rise_q.delete(); bits_q.delete();
        done_q.delete(); ovr_q.delete(); ldac_q.delete(); ldac_len_q.delete();
        rx_q.delete(); ev_cyc.delete(); ev_word.delete();
        exp_t.delete(); exp_w.delete(); exp_ovr.delete();
        ldac_bad = 0;
    endtask

    // Called just after a falling edge; dac_dv is high for exactly one cycle.
    task automatic send(input logic [15:0] w);
        if (sel) begin
            dac1 = w;
            dv1  = 1'b1;
        end else begin
            dac0 = w;
            dv0  = 1'b1;
        end
        ev_cyc.push_back(cyc);
        ev_word.push_back(w);
        @(negedge clk);
        dv0 = 1'b0;
        dv1 = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        int quiet = 0;
        int n     = 0;
        while (quiet < 3 && n < 5000) begin
            @(negedge clk);
            n++;
            quiet = m_busy ? 0 : quiet + 1;
        end
        check("idle_timeout", quiet, 3);
    endtask

    // Event-level model: a frame loaded at cycle t occupies t+1 .. t+L and
    // leaves the block idle again at t+1+L (the done cycle). Words arriving
    // while busy wait in one slot, latest wins, each overwrite flagged a
    // cycle later.
    task automatic run_model(input int len);
        int          cur_done = -1000000;
        bit          pend     = 1'b0;
        logic [15:0] pw       = 16'd0;
        exp_t.delete(); exp_w.delete(); exp_ovr.delete();
        for (int i = 0; i < ev_cyc.size(); i++) begin
            int c = ev_cyc[i];
            if (pend && cur_done <= c) begin
                exp_t.push_back(cur_done);
                exp_w.push_back(pw);
                cur_done = cur_done + 1 + len;
                pend     = 1'b0;
            end
            if (c >= cur_done) begin
                exp_t.push_back(c);
                exp_w.push_back(ev_word[i]);
                cur_done = c + 1 + len;
            end else begin
                if (pend) exp_ovr.push_back(c + 1);
                pend = 1'b1;
                pw   = ev_word[i];
            end
        end
        if (pend) begin
            exp_t.push_back(cur_done);
            exp_w.push_back(pw);
        end
    endtask

    task automatic check_segment(input string name);
        int d   = sel ? D1 : D0;
        int len = 35 * d + LDAC_PH * d;
        run_model(len);
        check({name, "_frames"}, rx_q.size(), exp_t.size());
        check({name, "_dones"}, done_q.size(), exp_t.size());
        check({name, "_overruns"}, ovr_q.size(), exp_ovr.size());
        check({name, "_ldac_during_cs"}, ldac_bad, 0);
`ifdef UPS_DAC_LDAC_EN
        check({name, "_ldac_pulses"}, ldac_q.size(), exp_t.size());
`else
        check({name, "_ldac_pulses"}, ldac_q.size(), 0);
`endif
        for (int i = 0; i < exp_t.size(); i++) begin
            if (i < rx_q.size()) begin
                check($sformatf("%s_word%0d", name, i), rx_q[i], exp_w[i]);
                check($sformatf("%s_bits%0d", name, i), bits_q[i], 16);
                check($sformatf("%s_cs_fall%0d", name, i), cs_fall_q[i], exp_t[i] + 1);
                check($sformatf("%s_cs_len%0d", name, i), len_q[i], 34 * d);
                check($sformatf("%s_first_rise%0d", name, i), rise_q[i], 2 * d);
            end
            if (i < done_q.size())
                check($sformatf("%s_done%0d", name, i), done_q[i], exp_t[i] + 1 + len);
`ifdef UPS_DAC_LDAC_EN
            if (i < ldac_q.size()) begin
                check($sformatf("%s_ldac_at%0d", name, i), ldac_q[i], exp_t[i] + 1 + 34 * d);
                check($sformatf("%s_ldac_len%0d", name, i), ldac_len_q[i], d);
            end
`endif
        end
        for (int i = 0; i < exp_ovr.size(); i++) begin
            if (i < ovr_q.size())
                check($sformatf("%s_overrun%0d", name, i), ovr_q[i], exp_ovr[i]);
        end
        clear_logs();
    endtask

    initial begin
        int t0;
        int n;
        int act;

        // Reset values, both instances, while reset is held.
        gap(3);
        check("rst_cs_n", cs0, 1);
        check("rst_sclk", sclk0, 0);
        check("rst_mosi", mosi0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_overrun", ovr0, 0);
        check("rst_ldac_n", ldac0, 1);
        check("rst_cs_n_d1", cs1, 1);
        check("rst_busy_d1", busy1, 0);
        rst_n = 1'b1;
        gap(5);
        check("idle_cs_n", cs0, 1);
        check("idle_busy", busy0, 0);

        // Single word
        t0 = cyc;
        send(16'hA5C3);
        check("single_busy_next", busy0, 1);
        check("single_cs_next", cs0, 0);
        wait_idle();
        if (rx_q.size() > 0) check("single_word_lit", rx_q[0], 16'hA5C3);
        if (done_q.size() > 0) check("single_done_lit", done_q[0] - t0, 141 + LDAC_PH * 4);
        check_segment("single");
        gap(4);

        // Back-to-back: second word waits in the pending slot.
        t0 = cyc;
        send(16'h1234);
        gap(9);
        send(16'h5678);
        wait_idle();
        if (cs_fall_q.size() > 1) check("b2b_second_fall_lit", cs_fall_q[1] - t0, 142 + LDAC_PH * 4);
        check_segment("b2b");
        gap(4);

        // Overrun: middle word is overwritten.
        send(16'h0001);
        gap(19);
        send(16'h0002);
        gap(19);
        send(16'h0003);
        wait_idle();
        check_segment("ovr");
        gap(4);

        // Random stream, gaps from back-to-back to longer than a frame.
        for (int i = 0; i < 14; i++) begin
            send(16'($urandom));
            gap(int'($urandom_range(180)));
        end
        wait_idle();
        check_segment("rand4");
        gap(4);

        // Reset mid-frame with a pending word queued behind it.
        send(16'($urandom));
        gap(20);
        send(16'h1111);
        n = 0;
        while (mon_bits < 7 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_seven_edges", mon_bits, 7);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_cs_n", cs0, 1);
        check("rst_mid_sclk", sclk0, 0);
        check("rst_mid_mosi", mosi0, 0);
        check("rst_mid_busy", busy0, 0);
        check("rst_mid_ldac_n", ldac0, 1);
        clear_logs();
        gap(3);
        rst_n = 1'b1;
        act = 0;
        repeat (50) begin
            @(negedge clk);
            if (!cs0 || busy0 || done0 || sclk0 || ovr0 || !ldac0) act++;
        end
        check("post_rst_activity", act, 0);
        check("post_rst_dones", done_q.size(), 0);
        check("post_rst_frames", cs_fall_q.size(), 0);
        send(16'hBEEF);
        wait_idle();
        check_segment("beef");

        // CLK_DIV = 1 instance
        sel = 1'b1;
        gap(3);
        t0 = cyc;
        send(16'hFFFF);
        send(16'h0000);
        wait_idle();
        if (done_q.size() > 0) check("d1_done_lit", done_q[0] - t0, 36 + LDAC_PH);
        check_segment("d1_pair");
        gap(2);
        for (int i = 0; i < 10; i++) begin
            send(16'($urandom));
            gap(int'($urandom_range(50)));
        end
        wait_idle();
        check_segment("rand1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
